// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: one load or store command becomes a single req/ack
// transaction, with lane steering, load extension, misalign detection and bus timeout.
module lsu_bus_master #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, ERR = 2'b10} state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    state_t          state_r;
    logic            st_store_r;
    logic            st_unsigned_r;
    logic [1:0]      st_size_r;
    logic [1:0]      st_off_r;
    logic [TO_W-1:0] to_cnt_r;

    function automatic logic is_bad(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   is_bad = 1'b0;
            2'b01:   is_bad = off[0];
            2'b10:   is_bad = (off != 2'b00);
            default: is_bad = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = 4'b0011 << {off[1], 1'b0};
            2'b10:   lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then truncate and extend.
    function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic uns,
                                                input logic [1:0] off, input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        case (sz)
            2'b00:   load_extend = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_extend = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    // Command FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            st_store_r    <= 1'b0;
            st_unsigned_r <= 1'b0;
            st_size_r     <= 2'b00;
            st_off_r      <= 2'b00;
            to_cnt_r      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            misalign      <= 1'b0;
            bus_err       <= 1'b0;
            rdata         <= 32'h0000_0000;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'h0000_0000;
            mem_be        <= 4'b0000;
            mem_wdata     <= 32'h0000_0000;
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        st_store_r    <= is_store;
                        st_unsigned_r <= ld_unsigned;
                        st_size_r     <= size;
                        st_off_r      <= addr[1:0];
                        busy          <= 1'b1;
                        to_cnt_r      <= '0;
                        if (is_bad(size, addr[1:0])) begin
                            state_r <= ERR;
                        end else begin
                            state_r   <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= lane_be(size, addr[1:0]);
                            mem_wdata <= is_store ? lane_wdata(size, wdata) : 32'h0000_0000;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        state_r  <= IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_be   <= 4'b0000;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        to_cnt_r <= '0;
                        if (!st_store_r) begin
                            rdata <= load_extend(st_size_r, st_unsigned_r, st_off_r, mem_rdata);
                        end else begin
                            rdata <= rdata;
                        end
                    end else if (to_cnt_r + TO_W'(1) == TO_LIMIT) begin
                        state_r  <= IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_be   <= 4'b0000;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        bus_err  <= 1'b1;
                        to_cnt_r <= '0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ERR: begin
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    misalign <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Randomized and directed bench for lsu_bus_master, checked against a byte-level
// reference model of the access rules.
module tb_lsu_bus_master;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        ld_unsigned = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, misalign, bus_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] prev_rd = 32'h0;
    logic [31:0] r;

    lsu_bus_master #(.TO_W(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .size(size),
        .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One command: cycle 0 is the current cycle; ack_at=0 means no ack is ever given.
    task automatic run_cmd(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int ack_at, input bit poke, input bit chain,
                           output logic [31:0] obs_rd);
        int          off, nb, exp_done, exp_req, done_c, req_c;
        logic        bad, exp_err, got, unstable, busy1, busy_d, mis_o, err_o;
        logic [3:0]  exp_be, c_be;
        logic [31:0] exp_wd, exp_rd, v, c_addr, c_wd;
        logic        c_we;
        off = int'(a[1:0]);
        bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        nb  = (sz == 2'b11) ? 4 : (1 << sz);
        exp_be = 4'b0000;
        exp_wd = 32'h0;
        v = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (!bad && i >= off && i < off + nb) exp_be[i] = 1'b1;
            if (st && !bad) exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*((off + i) % 4) +: 8];
        if (!uns && nb < 4 && v[8*nb-1]) begin
            for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        if (bad) begin
            exp_done = 2; exp_req = 0; exp_err = 1'b0; exp_rd = prev_rd;
        end else if (ack_at >= 1 && ack_at <= TMO) begin
            exp_done = ack_at + 1; exp_req = ack_at; exp_err = 1'b0;
            exp_rd = st ? prev_rd : v;
        end else begin
            exp_done = TMO + 1; exp_req = TMO; exp_err = 1'b1; exp_rd = prev_rd;
        end

        start = 1'b1; is_store = st; size = sz; ld_unsigned = uns;
        addr = a; wdata = wd; mem_rdata = rd;
        got = 1'b0; unstable = 1'b0; done_c = 0; req_c = 0; busy1 = 1'b0; busy_d = 1'b1;
        mis_o = 1'b0; err_o = 1'b0; obs_rd = 32'h0;
        c_addr = 32'h0; c_wd = 32'h0; c_be = 4'b0000; c_we = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 && poke) begin
                start = 1'b1; is_store = ~st; size = 2'b00; addr = ~a; wdata = ~wd;
            end else begin
                start = 1'b0;
            end
            mem_ack = (c == ack_at);
            @(negedge clk);
            if (c == 1) busy1 = busy;
            if (mem_req) begin
                if (req_c == 0) begin
                    c_addr = mem_addr; c_wd = mem_wdata; c_be = mem_be; c_we = mem_we;
                end else if (c_addr !== mem_addr || c_wd !== mem_wdata ||
                             c_be !== mem_be || c_we !== mem_we) begin
                    unstable = 1'b1;
                end
                req_c++;
            end
            if (done) begin
                got = 1'b1; done_c = c; mis_o = misalign; err_o = bus_err;
                obs_rd = rdata; busy_d = busy;
            end
            if (got) break;
        end

        chk_eq("done_seen", 32'(got), 32'd1);
        chk_eq("done_cycle", 32'(done_c), 32'(exp_done));
        chk_eq("req_cycles", 32'(req_c), 32'(exp_req));
        chk_eq("busy_c1", 32'(busy1), 32'd1);
        chk_eq("busy_done", 32'(busy_d), 32'd0);
        chk_eq("misalign", 32'(mis_o), 32'(bad));
        chk_eq("bus_err", 32'(err_o), 32'(exp_err));
        chk_eq("rdata", obs_rd, exp_rd);
        if (exp_req > 0) begin
            chk_eq("mem_addr", c_addr, {a[31:2], 2'b00});
            chk_eq("mem_be", 32'(c_be), 32'(exp_be));
            chk_eq("mem_wdata", c_wd, exp_wd);
            chk_eq("mem_we", 32'(c_we), 32'(st));
            chk_eq("bus_stable", 32'(unstable), 32'd0);
        end
        prev_rd = exp_rd;
        if (!chain) begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            chk_eq("done_pulse", 32'(done), 32'd0);
            chk_eq("req_after", 32'(mem_req), 32'd0);
            chk_eq("be_after", 32'(mem_be), 32'd0);
            chk_eq("busy_after", 32'(busy), 32'd0);
        end
    endtask

    logic [31:0] lb_s[4] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
    logic [31:0] lb_u[4] = '{32'h0000_0001, 32'h0000_007F, 32'h0000_00FF, 32'h0000_0080};

    initial begin
        #22;
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_req", 32'(mem_req), 32'd0);
        chk_eq("rst_rdata", rdata, 32'h0);
        chk_eq("rst_addr", mem_addr, 32'h0);
        chk_eq("rst_wdata", mem_wdata, 32'h0);
        chk_eq("rst_flags", {28'h0, mem_be}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_cmd(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1, 1'b0, 1'b0, r);
        run_cmd(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 2, 1'b0, 1'b0, r);
        chk_eq("lh_signed", r, 32'hFFFF_8001);
        run_cmd(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, 1'b0, 1'b0, r);
        chk_eq("lhu", r, 32'h0000_8001);
        for (int k = 0; k < 4; k++) begin
            run_cmd(1'b0, 2'b00, 1'b0, 32'h0000_4000 + 32'(k), 32'h0, 32'h80FF_7F01, 1, 1'b0, 1'b0, r);
            chk_eq("lb_signed", r, lb_s[k]);
            run_cmd(1'b0, 2'b00, 1'b1, 32'h0000_4000 + 32'(k), 32'h0, 32'h80FF_7F01, 1, 1'b0, 1'b0, r);
            chk_eq("lbu", r, lb_u[k]);
        end
        run_cmd(1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, r);
        chk_eq("misalign_keep", r, 32'h0000_0080);
        run_cmd(1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, r);
        run_cmd(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 32'h1234_5678, 0, 1'b0, 1'b0, r);
        run_cmd(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0, 32'h1234_5678, TMO, 1'b0, 1'b0, r);
        chk_eq("ack_last_cycle", r, 32'h1234_5678);
        run_cmd(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 3, 1'b1, 1'b0, r);
        run_cmd(1'b1, 2'b01, 1'b0, 32'h0000_7002, 32'h0000_BEEF, 32'h0, 2, 1'b0, 1'b1, r);
        run_cmd(1'b0, 2'b00, 1'b1, 32'h0000_7001, 32'h0, 32'h0000_9900, 1, 1'b0, 1'b0, r);
        chk_eq("b2b_load", r, 32'h0000_0099);

        // Asynchronous reset in the middle of a request.
        start = 1'b1; is_store = 1'b0; size = 2'b10; addr = 32'h0000_8000; mem_ack = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_eq("req_before_rst", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("rst_async_req", 32'(mem_req), 32'd0);
        chk_eq("rst_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < TMO + 3; c++) begin
            @(negedge clk);
            chk_eq("no_done_after_rst", {31'h0, done | mem_req}, 32'h0);
        end
        chk_eq("rst_rdata_clear", rdata, 32'h0);
        prev_rd = 32'h0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 150; t++) begin
            run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom, int'($urandom_range(0, TMO + 2)),
                    1'($urandom_range(0, 7) == 0), 1'b0, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store unit. Sits after the execute stage and consumes the effective address the ALU computes (rs1 + sign-extended imm).
- Turns one load or store command into a single request/acknowledge transaction on the data-memory bus.
- Generates byte enables and replicated write data for stores; extracts, then sign- or zero-extends, load data.
- Flags misaligned or illegal accesses and bus timeouts back to the pipeline.

Parameters:
- TO_W, 8, width of the bus-timeout counter.
- TIMEOUT, 255, number of REQ cycles without mem_ack before the access aborts (1..2^TO_W-1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  command valid; accepted only when busy=0
- is_store  input  1  1=store, 0=load
- size  input  2  00=byte, 01=half, 10=word, 11=illegal
- ld_unsigned  input  1  1=zero-extend load (LBU/LHU), 0=sign-extend
- addr  input  32  effective byte address
- wdata  input  32  store data (rs2)
- busy  output  1  command in flight
- done  output  1  one-cycle completion pulse
- rdata  output  32  extended load result, valid when done=1 on a load
- misalign  output  1  one-cycle pulse with done: misaligned or illegal-size access
- bus_err  output  1  one-cycle pulse with done: timeout abort
- mem_req  output  1  bus request
- mem_we  output  1  bus write enable
- mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_ack  input  1  bus acknowledge; for reads, mem_rdata is valid in the same cycle
- mem_rdata  input  32  bus read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, misalign, bus_err, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, rdata = 0; timeout counter=0. Asserting reset mid-transaction drops mem_req immediately; no done is generated.
- Every bus output and rdata is a register.
- FSM has three states: IDLE, REQ, ERR.
- IDLE:
  - On start=1, latch is_store, size, ld_unsigned and addr[1:0]; busy=1 from the next cycle.
  - Misaligned or illegal command goes to ERR. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. Illegal means size=11.
  - Any other command goes to REQ, with mem_req=1, mem_we=is_store, and mem_addr/mem_be/mem_wdata loaded in the same edge.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store data: byte={4{wdata[7:0]}}, half={2{wdata[15:0]}}, word=wdata. mem_wdata is 0 for loads.
- REQ:
  - Hold mem_req and all bus outputs stable until mem_ack=1.
  - The timeout counter increments each REQ cycle.
  - On mem_ack=1: go to IDLE; clear mem_req, busy, mem_we and mem_be; done=1 for one cycle.
  - For loads, on that same edge, register rdata = (mem_rdata >> 8*addr[1:0]) truncated to 8/16/32 bits, then sign- or zero-extended per ld_unsigned.
  - If the counter reaches TIMEOUT with no ack: go to IDLE, drop mem_req, done=1 and bus_err=1 for one cycle; rdata unchanged.
  - mem_ack arriving on the same cycle the counter reaches TIMEOUT counts as success (ack has priority).
- ERR: no bus activity. Next edge returns to IDLE with done=1, misalign=1 and busy=0.
- Stores and errors never modify rdata; rdata holds the last load result.
- Latency:
  - Start at cycle 0, mem_req high from cycle 1.
  - An ack in cycle k (k>=1) gives done in cycle k+1.
  - Minimum is 2 cycles. Misaligned access is 2 cycles.
- Back-to-back: start is honoured in the same cycle done=1 is high, since busy=0 in that cycle. start while busy=1 is ignored, with no queueing.
- mem_ack outside REQ is ignored.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000A5, size=00. Expect mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1. Ack in cycle 1 gives done in cycle 2, misalign=0.
- Signed load half: addr=0x2002, mem_rdata=0x8001_1234. Expect rdata=0xFFFF8001. Repeat with ld_unsigned=1: expect 0x00008001.
- Load byte at every addr[1:0] with mem_rdata=0x80FF7F01. Expect signed results 0x01, 0x7F, 0xFFFFFFFF, 0xFFFFFF80. Expect unsigned results 0x01, 0x7F, 0xFF, 0x80.
- Misaligned word: addr=0x3002, size=10. Expect mem_req never asserted, done=misalign=1 in cycle 2, rdata unchanged. Same result for size=11 at addr=0x3000.
- Timeout: TIMEOUT=4, no ack. Expect mem_req high in cycles 1-4, done=bus_err=1 in cycle 5. Separately, ack in cycle 4 gives a normal done with bus_err=0.
- Robustness:
  - start while busy is ignored.
  - start in the done cycle launches a new request on the next cycle.
  - rst_n low during REQ gives mem_req=0 asynchronously and no done.
